// File: rtl/tube_pkg.sv
// Shared constants and FSM state type for the Tube R3 block-transfer engine.
package tube_pkg;

    localparam logic [2:0] R3_STAT = 3'h4;
    localparam logic [2:0] R3_DATA = 3'h5;

    localparam int unsigned ST_AVAIL = 7;
    localparam int unsigned ST_NFULL = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_POLL,
        S_XFER,
        S_STORE,
        S_DONE
    } dma_state_t;

endpackage

// File: rtl/tube_bus_arb.sv
// Host Tube port mux: the CPU always wins; the DMA engine gets the port only when the CPU is silent.
module tube_bus_arb (
    input  logic       cpu_req,
    input  logic [2:0] cpu_addr,
    input  logic       cpu_rdnw,
    input  logic [7:0] cpu_wdata,
    input  logic       dma_act,
    input  logic [2:0] dma_addr,
    input  logic       dma_rdnw,
    input  logic [7:0] dma_wdata,
    output logic       t_cs_b,
    output logic [2:0] t_addr,
    output logic       t_rdnw,
    output logic [7:0] t_wdata,
    output logic       dma_go
);

    always_comb begin
        t_cs_b  = 1'b1;
        t_addr  = '0;
        t_rdnw  = 1'b1;
        t_wdata = '0;
        dma_go  = 1'b0;
        if (cpu_req) begin
            t_cs_b  = 1'b0;
            t_addr  = cpu_addr;
            t_rdnw  = cpu_rdnw;
            t_wdata = cpu_wdata;
        end else if (dma_act) begin
            t_cs_b  = 1'b0;
            t_addr  = dma_addr;
            t_rdnw  = dma_rdnw;
            t_wdata = dma_wdata;
            dma_go  = 1'b1;
        end
    end

endmodule

// File: rtl/tube_r3_dma_ctrl.sv
// Host-side block mover between host memory and the Tube R3 FIFO, polling R3 status before each byte.
module tube_r3_dma_ctrl
    import tube_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned LW       = 16,
    parameter int unsigned POLL_TMO = 1023
) (
    input  logic          h_phi2,
    input  logic          h_rst_b,
    input  logic          cpu_req,
    input  logic [2:0]    cpu_addr,
    input  logic          cpu_rdnw,
    input  logic [7:0]    cpu_wdata,
    output logic          t_cs_b,
    output logic [2:0]    t_addr,
    output logic          t_rdnw,
    output logic [7:0]    t_wdata,
    input  logic [7:0]    t_rdata,
    input  logic          cfg_start,
    input  logic          cfg_dir,
    input  logic [AW-1:0] cfg_addr,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_abort,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          done,
    output logic          err_tmo,
    output logic [LW-1:0] remain
);

    localparam int unsigned CW = $clog2(POLL_TMO + 1);

    dma_state_t    state, state_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [LW-1:0] remain_q, remain_n;
    logic          dir_q, dir_n;
    logic [7:0]    data_q, data_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          err_q, err_n;
    logic          abort_q, abort_n;
    logic          dma_act, dma_go;
    logic [2:0]    dma_addr;
    logic          dma_rdnw;
    logic [7:0]    dma_wdata;
    logic          last_byte;

    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            dir_q    <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state    <= state_n;
            addr_q   <= addr_n;
            remain_q <= remain_n;
            dir_q    <= dir_n;
            data_q   <= data_n;
            cnt_q    <= cnt_n;
            err_q    <= err_n;
            abort_q  <= abort_n;
        end
    end

    assign last_byte = (remain_q == LW'(1));

    // Abort is only honoured where the next state would be FETCH or POLL, so
    // an open memory handshake or bus transfer always runs to completion.
    always_comb begin
        state_n  = state;
        addr_n   = addr_q;
        remain_n = remain_q;
        dir_n    = dir_q;
        data_n   = data_q;
        cnt_n    = cnt_q;
        err_n    = err_q;
        abort_n  = abort_q | (cfg_abort && state != S_IDLE && state != S_DONE);
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    addr_n   = cfg_addr;
                    remain_n = cfg_len;
                    dir_n    = cfg_dir;
                    err_n    = 1'b0;
                    cnt_n    = '0;
                    abort_n  = 1'b0;
                    if (cfg_len == '0)
                        state_n = S_DONE;
                    else
                        state_n = cfg_dir ? S_POLL : S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    data_n  = mem_rdata;
                    state_n = abort_n ? S_DONE : S_POLL;
                end
            end
            S_POLL: begin
                if (dma_go) begin
                    if (dir_q ? t_rdata[ST_AVAIL] : t_rdata[ST_NFULL]) begin
                        cnt_n   = '0;
                        state_n = S_XFER;
                    end else if (cnt_q == CW'(POLL_TMO - 1)) begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                        if (abort_n)
                            state_n = S_DONE;
                    end
                end
            end
            S_XFER: begin
                if (dma_go) begin
                    if (dir_q) begin
                        data_n  = t_rdata;
                        state_n = S_STORE;
                    end else begin
                        addr_n = addr_q + AW'(1);
                        if (remain_q != '0)
                            remain_n = remain_q - LW'(1);
                        state_n = (last_byte || abort_n) ? S_DONE : S_FETCH;
                    end
                end
            end
            S_STORE: begin
                if (mem_ack) begin
                    addr_n = addr_q + AW'(1);
                    if (remain_q != '0)
                        remain_n = remain_q - LW'(1);
                    state_n = (last_byte || abort_n) ? S_DONE : S_POLL;
                end
            end
            S_DONE: begin
                abort_n = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign dma_act   = (state == S_POLL) || (state == S_XFER);
    assign dma_addr  = (state == S_XFER) ? R3_DATA : R3_STAT;
    assign dma_rdnw  = (state == S_XFER) ? dir_q : 1'b1;
    assign dma_wdata = (state == S_XFER && !dir_q) ? data_q : '0;

    tube_bus_arb u_arb (
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_rdnw  (cpu_rdnw),
        .cpu_wdata (cpu_wdata),
        .dma_act   (dma_act),
        .dma_addr  (dma_addr),
        .dma_rdnw  (dma_rdnw),
        .dma_wdata (dma_wdata),
        .t_cs_b    (t_cs_b),
        .t_addr    (t_addr),
        .t_rdnw    (t_rdnw),
        .t_wdata   (t_wdata),
        .dma_go    (dma_go)
    );

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err_tmo   = err_q;
    assign remain    = remain_q;
    assign mem_req   = (state == S_FETCH) || (state == S_STORE);
    assign mem_we    = (state == S_STORE);
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

endmodule

// File: tb/tb_tube_r3_dma_ctrl.sv
// Directed bench for tube_r3_dma_ctrl with a behavioural Tube R3 port and a one-wait-state memory.
module tb_tube_r3_dma_ctrl;

    logic        h_phi2 = 1'b0;
    logic        h_rst_b;
    logic        cpu_req;
    logic [2:0]  cpu_addr;
    logic        cpu_rdnw;
    logic [7:0]  cpu_wdata;
    logic        t_cs_b;
    logic [2:0]  t_addr;
    logic        t_rdnw;
    logic [7:0]  t_wdata;
    logic [7:0]  t_rdata;
    logic        cfg_start;
    logic        cfg_dir;
    logic [15:0] cfg_addr;
    logic [15:0] cfg_len;
    logic        cfg_abort;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        err_tmo;
    logic [15:0] remain;

    // Bench-driven Tube model state
    logic [7:0]  stv;
    int          avail_at;
    logic [7:0]  r3d [0:255];

    // Monitor/responder state (only written by the always blocks below)
    int          polls_total = 0;
    int          dma_total   = 0;
    int          r3_rd       = 0;
    int          wr_n        = 0;
    logic [7:0]  wr_log [0:255];
    int          mw_n        = 0;
    int          acks_total  = 0;
    logic [15:0] mw_addr [0:255];
    logic [7:0]  mw_data [0:255];

    int pass_n = 0;
    int tot_n  = 0;

    always #5 h_phi2 = ~h_phi2;

    tube_r3_dma_ctrl #(.AW(16), .LW(16), .POLL_TMO(8)) dut (
        .h_phi2    (h_phi2),
        .h_rst_b   (h_rst_b),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_rdnw  (cpu_rdnw),
        .cpu_wdata (cpu_wdata),
        .t_cs_b    (t_cs_b),
        .t_addr    (t_addr),
        .t_rdnw    (t_rdnw),
        .t_wdata   (t_wdata),
        .t_rdata   (t_rdata),
        .cfg_start (cfg_start),
        .cfg_dir   (cfg_dir),
        .cfg_addr  (cfg_addr),
        .cfg_len   (cfg_len),
        .cfg_abort (cfg_abort),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .err_tmo   (err_tmo),
        .remain    (remain)
    );

    always_comb begin
        t_rdata = 8'h00;
        if (t_addr == 3'h4)
            t_rdata = (polls_total >= avail_at) ? stv : 8'h00;
        else if (t_addr == 3'h5)
            t_rdata = r3d[8'(r3_rd)];
    end

    assign mem_rdata = mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h5C;

    always @(posedge h_phi2) begin
        if (h_rst_b && !t_cs_b && !cpu_req) begin
            dma_total <= dma_total + 1;
            if (t_addr == 3'h4)
                polls_total <= polls_total + 1;
            if (t_addr == 3'h5 && !t_rdnw) begin
                wr_log[8'(wr_n)] <= t_wdata;
                wr_n <= wr_n + 1;
            end
            if (t_addr == 3'h5 && t_rdnw)
                r3_rd <= r3_rd + 1;
        end
    end

    always @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            mem_ack <= 1'b0;
        end else begin
            mem_ack <= mem_req && !mem_ack;
            if (mem_ack)
                acks_total <= acks_total + 1;
            if (mem_ack && mem_req && mem_we) begin
                mw_addr[8'(mw_n)] <= mem_addr;
                mw_data[8'(mw_n)] <= mem_wdata;
                mw_n <= mw_n + 1;
            end
        end
    end

    task automatic tick();
        @(posedge h_phi2);
        #1;
    endtask

    task automatic start(input logic d, input logic [15:0] a, input logic [15:0] l);
        cfg_dir   = d;
        cfg_addr  = a;
        cfg_len   = l;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        h_rst_b = 1'b0;
        repeat (2) tick();
        tot_n++;
        if ({busy, done, err_tmo} !== 3'b000)
            $display("FAIL reset_flags: busy/done/err=%b expected 000", {busy, done, err_tmo});
        else pass_n++;
        tot_n++;
        if (remain !== 16'h0000)
            $display("FAIL reset_remain: got %h expected 0000", remain);
        else pass_n++;
        tot_n++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b0, 16'h0000, 8'h00})
            $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h expected 0 0 0000 00",
                     mem_req, mem_we, mem_addr, mem_wdata);
        else pass_n++;
        tot_n++;
        if ({t_cs_b, t_addr, t_rdnw, t_wdata} !== {1'b1, 3'h0, 1'b1, 8'h00})
            $display("FAIL reset_tube: cs_b=%b addr=%h rdnw=%b wdata=%h expected 1 0 1 00",
                     t_cs_b, t_addr, t_rdnw, t_wdata);
        else pass_n++;
        h_rst_b = 1'b1;
        repeat (2) tick();
        tot_n++;
        if (busy !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b expected 0", busy);
        else pass_n++;
    endtask

    task automatic test_mem_to_r3();
        int w0;
        bit seen;
        logic [7:0] exp_b [0:2];
        exp_b[0] = 8'h4C; exp_b[1] = 8'h4D; exp_b[2] = 8'h4E;
        w0 = wr_n;
        stv = 8'h40;
        avail_at = polls_total;
        start(1'b0, 16'h1000, 16'd3);
        wait_done(60, seen);
        tot_n++;
        if (!seen) $display("FAIL fwd_done: no done pulse within budget");
        else pass_n++;
        tot_n++;
        if (wr_n - w0 != 3) $display("FAIL fwd_count: wrote %0d bytes expected 3", wr_n - w0);
        else pass_n++;
        for (int k = 0; k < 3; k++) begin
            tot_n++;
            if (wr_log[8'(w0 + k)] !== exp_b[k])
                $display("FAIL fwd_byte%0d: got %h expected %h", k, wr_log[8'(w0 + k)], exp_b[k]);
            else pass_n++;
        end
        tot_n++;
        if (remain !== 16'd0 || err_tmo !== 1'b0)
            $display("FAIL fwd_end: remain=%h err=%b expected 0000 0", remain, err_tmo);
        else pass_n++;
        tick();
        tot_n++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL fwd_pulse: done=%b busy=%b expected 0 0", done, busy);
        else pass_n++;
    endtask

    task automatic test_r3_to_mem();
        int p0, m0;
        bit seen;
        p0 = polls_total;
        m0 = mw_n;
        stv = 8'h80;
        avail_at = p0 + 5;
        r3d[8'(r3_rd)]     = 8'hA5;
        r3d[8'(r3_rd + 1)] = 8'h5A;
        start(1'b1, 16'h2000, 16'd2);
        wait_done(80, seen);
        tot_n++;
        if (!seen) $display("FAIL rev_done: no done pulse within budget");
        else pass_n++;
        tot_n++;
        if (mw_n - m0 != 2) $display("FAIL rev_count: %0d stores expected 2", mw_n - m0);
        else pass_n++;
        tot_n++;
        if ({mw_addr[8'(m0)], mw_data[8'(m0)]} !== {16'h2000, 8'hA5})
            $display("FAIL rev_store0: got %h=%h expected 2000=a5", mw_addr[8'(m0)], mw_data[8'(m0)]);
        else pass_n++;
        tot_n++;
        if ({mw_addr[8'(m0 + 1)], mw_data[8'(m0 + 1)]} !== {16'h2001, 8'h5A})
            $display("FAIL rev_store1: got %h=%h expected 2001=5a",
                     mw_addr[8'(m0 + 1)], mw_data[8'(m0 + 1)]);
        else pass_n++;
        tot_n++;
        if (polls_total - p0 != 7) $display("FAIL rev_polls: %0d polls expected 7", polls_total - p0);
        else pass_n++;
        tick();
    endtask

    task automatic test_cpu_share();
        int w0;
        bit seen;
        w0 = wr_n;
        stv = 8'h40;
        avail_at = polls_total;
        start(1'b0, 16'h3000, 16'd2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (t_cs_b === 1'b0 && t_addr === 3'h4) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        tot_n++;
        if (!seen) $display("FAIL share_poll: DMA never reached a status poll");
        else pass_n++;
        cpu_addr  = 3'h2;
        cpu_rdnw  = 1'b0;
        cpu_wdata = 8'h3C;
        cpu_req   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            tot_n++;
            if ({t_cs_b, t_addr, t_rdnw, t_wdata} !== {1'b0, 3'h2, 1'b0, 8'h3C})
                $display("FAIL share_mirror%0d: cs_b=%b addr=%h rdnw=%b wdata=%h expected 0 2 0 3c",
                         k, t_cs_b, t_addr, t_rdnw, t_wdata);
            else pass_n++;
            tick();
        end
        cpu_req = 1'b0;
        #1;
        tot_n++;
        if ({t_cs_b, t_addr} !== {1'b0, 3'h4})
            $display("FAIL share_resume: cs_b=%b addr=%h expected 0 4", t_cs_b, t_addr);
        else pass_n++;
        wait_done(60, seen);
        tot_n++;
        if (!seen || wr_n - w0 != 2)
            $display("FAIL share_count: done=%b bytes=%0d expected 1 2", seen, wr_n - w0);
        else pass_n++;
        tot_n++;
        if ({wr_log[8'(w0)], wr_log[8'(w0 + 1)]} !== {8'h6C, 8'h6D})
            $display("FAIL share_bytes: got %h %h expected 6c 6d", wr_log[8'(w0)], wr_log[8'(w0 + 1)]);
        else pass_n++;
        tick();
    endtask

    task automatic test_timeout();
        int p0;
        bit seen;
        p0 = polls_total;
        stv = 8'h80;
        avail_at = p0 + 1000;
        start(1'b1, 16'h4000, 16'd5);
        wait_done(40, seen);
        tot_n++;
        if (!seen) $display("FAIL tmo_done: no done pulse within budget");
        else pass_n++;
        tot_n++;
        if (polls_total - p0 != 8) $display("FAIL tmo_polls: %0d polls expected 8", polls_total - p0);
        else pass_n++;
        tot_n++;
        if (err_tmo !== 1'b1) $display("FAIL tmo_err: err_tmo=%b expected 1", err_tmo);
        else pass_n++;
        tot_n++;
        if (remain !== 16'd5) $display("FAIL tmo_remain: got %h expected 0005", remain);
        else pass_n++;
        repeat (3) tick();
        tot_n++;
        if (err_tmo !== 1'b1 || busy !== 1'b0)
            $display("FAIL tmo_sticky: err=%b busy=%b expected 1 0", err_tmo, busy);
        else pass_n++;
    endtask

    task automatic test_len0_wrap();
        int d0, a0, m0;
        bit seen;
        d0 = dma_total;
        a0 = acks_total;
        start(1'b0, 16'h1234, 16'd0);
        tot_n++;
        if (done !== 1'b1 || err_tmo !== 1'b0)
            $display("FAIL len0_done: done=%b err=%b expected 1 0", done, err_tmo);
        else pass_n++;
        tick();
        tot_n++;
        if (done !== 1'b0 || busy !== 1'b0 || dma_total != d0 || acks_total != a0)
            $display("FAIL len0_quiet: done=%b busy=%b bus=%0d mem=%0d expected 0 0 0 0",
                     done, busy, dma_total - d0, acks_total - a0);
        else pass_n++;
        m0 = mw_n;
        stv = 8'h80;
        avail_at = polls_total;
        r3d[8'(r3_rd)]     = 8'h9A;
        r3d[8'(r3_rd + 1)] = 8'hBC;
        start(1'b1, 16'hFFFF, 16'd2);
        wait_done(60, seen);
        tot_n++;
        if (!seen || mw_n - m0 != 2)
            $display("FAIL wrap_count: done=%b stores=%0d expected 1 2", seen, mw_n - m0);
        else pass_n++;
        tot_n++;
        if ({mw_addr[8'(m0)], mw_data[8'(m0)], mw_addr[8'(m0 + 1)], mw_data[8'(m0 + 1)]}
            !== {16'hFFFF, 8'h9A, 16'h0000, 8'hBC})
            $display("FAIL wrap_stores: got %h=%h %h=%h expected ffff=9a 0000=bc",
                     mw_addr[8'(m0)], mw_data[8'(m0)], mw_addr[8'(m0 + 1)], mw_data[8'(m0 + 1)]);
        else pass_n++;
        tick();
    endtask

    task automatic test_abort();
        int d0, m0;
        bit seen;
        stv = 8'h80;
        avail_at = polls_total;
        for (int k = 0; k < 4; k++)
            r3d[8'(r3_rd + k)] = 8'(8'h11 * (k + 1));
        m0 = mw_n;
        start(1'b1, 16'h5000, 16'd4);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req === 1'b1 && mem_we === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        tot_n++;
        if (!seen) $display("FAIL abort_store: never reached a store");
        else pass_n++;
        d0 = dma_total;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        wait_done(10, seen);
        tot_n++;
        if (!seen) $display("FAIL abort_done: no done pulse within budget");
        else pass_n++;
        tot_n++;
        if (remain !== 16'd3) $display("FAIL abort_remain: got %h expected 0003", remain);
        else pass_n++;
        tot_n++;
        if (mw_n - m0 != 1 || {mw_addr[8'(m0)], mw_data[8'(m0)]} !== {16'h5000, 8'h11})
            $display("FAIL abort_mem: stores=%0d first %h=%h expected 1 5000=11",
                     mw_n - m0, mw_addr[8'(m0)], mw_data[8'(m0)]);
        else pass_n++;
        tot_n++;
        if (dma_total != d0) $display("FAIL abort_bus: %0d extra bus cycles expected 0", dma_total - d0);
        else pass_n++;
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        stv = 8'h40;
        avail_at = polls_total;
        start(1'b0, 16'h6000, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (t_cs_b === 1'b0 && t_addr === 3'h5) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        tot_n++;
        if (!seen) $display("FAIL rstmid_xfer: never reached a data transfer");
        else pass_n++;
        h_rst_b = 1'b0;
        #1;
        tot_n++;
        if ({busy, done, err_tmo, remain, mem_req, mem_we, mem_addr, mem_wdata}
            !== {1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00})
            $display("FAIL rstmid_state: busy=%b done=%b err=%b remain=%h req=%b we=%b addr=%h wdata=%h expected all 0",
                     busy, done, err_tmo, remain, mem_req, mem_we, mem_addr, mem_wdata);
        else pass_n++;
        tot_n++;
        if ({t_cs_b, t_addr, t_rdnw, t_wdata} !== {1'b1, 3'h0, 1'b1, 8'h00})
            $display("FAIL rstmid_tube: cs_b=%b addr=%h rdnw=%b wdata=%h expected 1 0 1 00",
                     t_cs_b, t_addr, t_rdnw, t_wdata);
        else pass_n++;
        tick();
        h_rst_b = 1'b1;
        repeat (3) tick();
        tot_n++;
        if (busy !== 1'b0 || t_cs_b !== 1'b1)
            $display("FAIL rstmid_idle: busy=%b cs_b=%b expected 0 1", busy, t_cs_b);
        else pass_n++;
    endtask

    initial begin
        h_rst_b   = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = 3'h0;
        cpu_rdnw  = 1'b1;
        cpu_wdata = 8'h00;
        cfg_start = 1'b0;
        cfg_dir   = 1'b0;
        cfg_addr  = 16'h0000;
        cfg_len   = 16'h0000;
        cfg_abort = 1'b0;
        stv       = 8'h00;
        avail_at  = 0;
        for (int i = 0; i < 256; i++)
            r3d[i] = 8'h00;

        test_reset();
        test_mem_to_r3();
        test_r3_to_mem();
        test_cpu_share();
        test_timeout();
        test_len0_wrap();
        test_abort();
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
